if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_if.sv | 22 ++
 rtl/if_stage.sv | 99 +++++++++
 tb/tb_if_stage.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus between the IF stage (master) and the instruction memory (slave).
// The IF stage drives the address and request; the memory returns ready and data for that address.
interface if_stage_if;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_addr,
        output imem_req,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, pending-redirect latch and the IF/ID pipeline register.
// Redirects have delay-slot semantics; a redirect seen while not advancing is held until the next advance.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    if_stage_if.master         imem,
    output logic [31:0]        id_instr,
    output logic [31:0]        id_pc4,
    output logic               id_valid
);

    logic [31:0] pc_q,       pc_d;
    logic        pend_vld_q, pend_vld_d;
    logic [31:0] pend_pc_q,  pend_pc_d;
    logic [31:0] instr_q,    instr_d;
    logic [31:0] pc4_q,      pc4_d;
    logic        valid_q,    valid_d;

    logic        advance;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_aligned;

    assign advance          = !stall && imem.imem_ready;
    assign pc_plus4         = pc_q + 32'd4;
    assign redirect_aligned = {redirect_pc[31:2], 2'b00};

    // Fetch request tracks reset directly so the very first edge after release already fetches.
    assign imem.imem_addr = pc_q;
    assign imem.imem_req  = reset;

    always_comb begin
        pc_d       = pc_q;
        pend_vld_d = pend_vld_q;
        pend_pc_d  = pend_pc_q;

        if (advance) begin
            pend_vld_d = 1'b0;
            if (redirect) begin
                pc_d = redirect_aligned;
            end else if (pend_vld_q) begin
                pc_d = pend_pc_q;
            end else begin
                pc_d = pc_plus4;
            end
        end else if (redirect) begin
            // Latest redirect wins while the stage cannot advance.
            pend_vld_d = 1'b1;
            pend_pc_d  = redirect_aligned;
        end
    end

    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;

        if (flush) begin
            instr_d = 32'h0;
            valid_d = 1'b0;
        end else if (advance) begin
            instr_d = imem.imem_rdata;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
        end else if (!stall) begin
            // Memory not ready: inject a bubble, keep the last PC+4.
            instr_d = 32'h0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            pend_vld_q <= 1'b0;
            pend_pc_q  <= 32'h0;
            instr_q    <= 32'h0;
            pc4_q      <= 32'h0;
            valid_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pend_vld_q <= pend_vld_d;
            pend_pc_q  <= pend_pc_d;
            instr_q    <= instr_d;
            pc4_q      <= pc4_d;
            valid_q    <= valid_d;
        end
    end

    assign id_instr = instr_q;
    assign id_pc4   = pc4_q;
    assign id_valid = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: instruction memory returns a fixed address-derived word.
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic        id_valid;

    int vec_cnt;
    int err_cnt;

    if_stage_if imem ();

    if_stage #(.RESET_PC(32'h0000_3000)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem.master),
        .id_instr    (id_instr),
        .id_pc4      (id_pc4),
        .id_valid    (id_valid)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    assign imem.imem_rdata = word(imem.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_cnt         = 0;
        err_cnt         = 0;
        reset           = 1'b0;
        stall           = 1'b0;
        flush           = 1'b0;
        redirect        = 1'b0;
        redirect_pc     = 32'h0;
        imem.imem_ready = 1'b1;

        #12;
        chk("rst_addr",  imem.imem_addr, 32'h3000);
        chk("rst_req",   {31'h0, imem.imem_req}, 32'h0);
        chk("rst_valid", {31'h0, id_valid}, 32'h0);
        chk("rst_instr", id_instr, 32'h0);
        chk("rst_pc4",   id_pc4, 32'h0);

        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("req_on", {31'h0, imem.imem_req}, 32'h1);

        // Sequential fetch
        step();
        chk("seq1_addr",  imem.imem_addr, 32'h3004);
        chk("seq1_instr", id_instr, word(32'h3000));
        chk("seq1_pc4",   id_pc4, 32'h3004);
        chk("seq1_valid", {31'h0, id_valid}, 32'h1);
        step();
        chk("seq2_addr",  imem.imem_addr, 32'h3008);
        chk("seq2_pc4",   id_pc4, 32'h3008);

        // Redirect with delay slot; low bits of target ignored
        redirect = 1'b1; redirect_pc = 32'h0000_3102;
        step();
        redirect = 1'b0;
        chk("ds_instr", id_instr, word(32'h3008));
        chk("ds_pc4",   id_pc4, 32'h300C);
        chk("ds_addr",  imem.imem_addr, 32'h3100);

        redirect = 1'b1; redirect_pc = 32'h0000_3010;
        step();
        redirect = 1'b0;
        chk("to3010_addr", imem.imem_addr, 32'h3010);

        // Stall two cycles with redirect in first
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_3200;
        step();
        redirect = 1'b0;
        chk("st1_addr",  imem.imem_addr, 32'h3010);
        chk("st1_instr", id_instr, word(32'h3100));
        chk("st1_pc4",   id_pc4, 32'h3104);
        step();
        chk("st2_addr",  imem.imem_addr, 32'h3010);
        chk("st2_instr", id_instr, word(32'h3100));
        chk("st2_valid", {31'h0, id_valid}, 32'h1);
        stall = 1'b0;
        step();
        chk("st_rel_instr", id_instr, word(32'h3010));
        chk("st_rel_pc4",   id_pc4, 32'h3014);
        chk("st_rel_addr",  imem.imem_addr, 32'h3200);

        // PC wrap
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        chk("wrap_addr0", imem.imem_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_addr1", imem.imem_addr, 32'h0);
        chk("wrap_pc4",   id_pc4, 32'h0);
        chk("wrap_instr", id_instr, word(32'hFFFF_FFFC));
        step();
        chk("wrap_pc4b",  id_pc4, 32'h4);

        // Memory not ready for three cycles
        redirect = 1'b1; redirect_pc = 32'h0000_3020;
        step();
        redirect = 1'b0;
        imem.imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("nr_addr",  imem.imem_addr, 32'h3020);
            chk("nr_valid", {31'h0, id_valid}, 32'h0);
            chk("nr_instr", id_instr, 32'h0);
            chk("nr_pc4",   id_pc4, 32'h8);
        end
        imem.imem_ready = 1'b1;
        step();
        chk("nr_rel_instr", id_instr, word(32'h3020));
        chk("nr_rel_valid", {31'h0, id_valid}, 32'h1);
        chk("nr_rel_addr",  imem.imem_addr, 32'h3024);

        // Two redirects while not ready: latest wins
        imem.imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_3300;
        step();
        redirect_pc = 32'h0000_3400;
        step();
        redirect = 1'b0; imem.imem_ready = 1'b1;
        step();
        chk("multi_instr", id_instr, word(32'h3024));
        chk("multi_addr",  imem.imem_addr, 32'h3400);

        // Flush under stall
        stall = 1'b1; flush = 1'b1;
        step();
        chk("fls_valid", {31'h0, id_valid}, 32'h0);
        chk("fls_instr", id_instr, 32'h0);
        chk("fls_pc4",   id_pc4, 32'h3028);
        chk("fls_addr",  imem.imem_addr, 32'h3400);
        stall = 1'b0; flush = 1'b0;
        step();
        chk("fls_rel_instr", id_instr, word(32'h3400));
        chk("fls_rel_addr",  imem.imem_addr, 32'h3404);

        // Flush while advancing: PC still moves
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flsa_valid", {31'h0, id_valid}, 32'h0);
        chk("flsa_addr",  imem.imem_addr, 32'h3408);

        // Async reset with pending redirect
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_3500;
        step();
        redirect = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_addr",  imem.imem_addr, 32'h3000);
        chk("arst_valid", {31'h0, id_valid}, 32'h0);
        chk("arst_instr", id_instr, 32'h0);
        chk("arst_pc4",   id_pc4, 32'h0);
        chk("arst_req",   {31'h0, imem.imem_req}, 32'h0);
        stall = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("post_instr", id_instr, word(32'h3000));
        chk("post_addr",  imem.imem_addr, 32'h3004);
        step();
        chk("post_addr2", imem.imem_addr, 32'h3008);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
